// File: rtl/dcache_controller_pkg.sv
// Shared definitions for the direct-mapped write-back data cache:
// address/block geometry and the controller state encoding.
package dcache_controller_pkg;

  localparam int ADDR_BITS       = 8;
  localparam int BLOCK_BYTES     = 4;
  localparam int BLOCK_BITS      = BLOCK_BYTES * 8;
  localparam int OFFSET_BITS     = $clog2(BLOCK_BYTES);
  localparam int BLOCK_ADDR_BITS = ADDR_BITS - OFFSET_BITS;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_FETCH     = 2'd2,
    S_UPDATE    = 2'd3
  } cache_state_e;

endpackage

// File: rtl/dcache_controller_if.sv
// Bus interfaces of the data cache: the CPU load/store side and the
// block-wide memory side. "master" is the side that issues requests.
interface dcache_cpu_if;
  import dcache_controller_pkg::*;

  logic                 READ;
  logic                 WRITE;
  logic [ADDR_BITS-1:0] ADDRESS;
  logic [7:0]           WRITEDATA;
  logic [7:0]           READDATA;
  logic                 BUSYWAIT;

  modport master (output READ, WRITE, ADDRESS, WRITEDATA,
                  input  READDATA, BUSYWAIT);
  modport slave  (input  READ, WRITE, ADDRESS, WRITEDATA,
                  output READDATA, BUSYWAIT);
endinterface

interface dcache_mem_if;
  import dcache_controller_pkg::*;

  logic                       MEM_READ;
  logic                       MEM_WRITE;
  logic [BLOCK_ADDR_BITS-1:0] MEM_ADDRESS;
  logic [BLOCK_BITS-1:0]      MEM_WRITEDATA;
  logic [BLOCK_BITS-1:0]      MEM_READDATA;
  logic                       MEM_BUSYWAIT;

  modport master (output MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA,
                  input  MEM_READDATA, MEM_BUSYWAIT);
  modport slave  (input  MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA,
                  output MEM_READDATA, MEM_BUSYWAIT);
endinterface

// File: rtl/dcache_controller_array.sv
// Cache storage: valid/dirty bits (cleared by reset) plus tag and data
// arrays (never cleared). One asynchronous read port by index, one
// byte-write port for CPU stores and one block-write port for fills.
module dcache_array
  import dcache_controller_pkg::*;
#(
  parameter int INDEX_BITS = 3,
  parameter int TAG_BITS   = 3
) (
  input  logic                   CLK,
  input  logic                   RESET,
  // lookup
  input  logic [INDEX_BITS-1:0]  rd_idx,
  output logic                   rd_valid,
  output logic                   rd_dirty,
  output logic [TAG_BITS-1:0]    rd_tag,
  output logic [BLOCK_BITS-1:0]  rd_block,
  // CPU store
  input  logic                   byte_we,
  input  logic [INDEX_BITS-1:0]  byte_idx,
  input  logic [OFFSET_BITS-1:0] byte_off,
  input  logic [7:0]             byte_data,
  // block fill
  input  logic                   block_we,
  input  logic [INDEX_BITS-1:0]  block_idx,
  input  logic [TAG_BITS-1:0]    block_tag,
  input  logic [BLOCK_BITS-1:0]  block_data
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]      valid_q, valid_d;
  logic [LINES-1:0]      dirty_q, dirty_d;
  logic [TAG_BITS-1:0]   tag_mem  [LINES];
  logic [BLOCK_BITS-1:0] data_mem [LINES];

  // Status bit updates: a store marks its line dirty, a fill makes it valid and clean.
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (byte_we) begin
      dirty_d[byte_idx] = 1'b1;
    end
    if (block_we) begin
      valid_d[block_idx] = 1'b1;
      dirty_d[block_idx] = 1'b0;
    end
  end

  // Status bits are the only storage that reset clears.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and data arrays; a fill and a store never target the same cycle.
  always_ff @(posedge CLK) begin
    if (block_we) begin
      tag_mem[block_idx]  <= block_tag;
      data_mem[block_idx] <= block_data;
    end else if (byte_we) begin
      data_mem[byte_idx][{byte_off, 3'b000} +: 8] <= byte_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_dirty = dirty_q[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_block = data_mem[rd_idx];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back data cache controller between the 8-bit CPU
// load/store path and 32-bit block memory. Hits complete in the request
// cycle; misses walk WRITEBACK (if dirty) -> FETCH -> UPDATE.
module dcache_controller
  import dcache_controller_pkg::*;
#(
  parameter int INDEX_BITS = 3
) (
  input  logic         CLK,
  input  logic         RESET,
  dcache_cpu_if.slave  cpu,
  dcache_mem_if.master mem
);

  localparam int TAG_BITS = BLOCK_ADDR_BITS - INDEX_BITS;

  cache_state_e          state_q, state_d;
  logic [TAG_BITS-1:0]   miss_tag_q, miss_tag_d;
  logic [INDEX_BITS-1:0] miss_idx_q, miss_idx_d;
  logic [BLOCK_BITS-1:0] fill_q, fill_d;

  logic [TAG_BITS-1:0]    req_tag;
  logic [INDEX_BITS-1:0]  req_idx;
  logic [OFFSET_BITS-1:0] req_off;
  logic [INDEX_BITS-1:0]  lookup_idx;

  logic                  rd_valid, rd_dirty;
  logic [TAG_BITS-1:0]   rd_tag;
  logic [BLOCK_BITS-1:0] rd_block;

  logic request, hit, idle_hit;
  logic byte_we, block_we;
  logic mem_read, mem_write;
  logic [BLOCK_ADDR_BITS-1:0] mem_address;
  logic [BLOCK_BITS-1:0]      mem_writedata;

  assign req_tag = cpu.ADDRESS[ADDR_BITS-1 -: TAG_BITS];
  assign req_idx = cpu.ADDRESS[OFFSET_BITS +: INDEX_BITS];
  assign req_off = cpu.ADDRESS[OFFSET_BITS-1:0];

  // While a miss is in flight the latched index owns the lookup port, so
  // the fill completes even if the CPU drops or changes its request.
  assign lookup_idx = (state_q == S_IDLE) ? req_idx : miss_idx_q;

  dcache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_array (
    .CLK        (CLK),
    .RESET      (RESET),
    .rd_idx     (lookup_idx),
    .rd_valid   (rd_valid),
    .rd_dirty   (rd_dirty),
    .rd_tag     (rd_tag),
    .rd_block   (rd_block),
    .byte_we    (byte_we),
    .byte_idx   (req_idx),
    .byte_off   (req_off),
    .byte_data  (cpu.WRITEDATA),
    .block_we   (block_we),
    .block_idx  (miss_idx_q),
    .block_tag  (miss_tag_q),
    .block_data (fill_q)
  );

  assign request  = cpu.READ | cpu.WRITE;
  assign hit      = rd_valid && (rd_tag == req_tag);
  assign idle_hit = (state_q == S_IDLE) && hit;

  // Reset forces the stall low immediately rather than waiting for the
  // cleared valid bits to turn a pending request into a miss.
  assign cpu.BUSYWAIT = !RESET && request && !idle_hit;
  assign cpu.READDATA = (!RESET && cpu.READ && idle_hit) ? rd_block[{req_off, 3'b000} +: 8] : 8'h00;

  // Next-state and memory-side outputs; memory strobes are decoded from state only.
  always_comb begin
    state_d       = state_q;
    miss_tag_d    = miss_tag_q;
    miss_idx_d    = miss_idx_q;
    fill_d        = fill_q;
    byte_we       = 1'b0;
    block_we      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;

    unique case (state_q)
      S_IDLE: begin
        if (request) begin
          if (hit) begin
            byte_we = cpu.WRITE;
          end else begin
            miss_tag_d = req_tag;
            miss_idx_d = req_idx;
            state_d    = rd_dirty ? S_WRITEBACK : S_FETCH;
          end
        end
      end
      S_WRITEBACK: begin
        mem_write     = 1'b1;
        mem_address   = {rd_tag, miss_idx_q};
        mem_writedata = rd_block;
        if (!mem.MEM_BUSYWAIT) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        mem_read    = 1'b1;
        mem_address = {miss_tag_q, miss_idx_q};
        if (!mem.MEM_BUSYWAIT) begin
          fill_d  = mem.MEM_READDATA;
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        block_we = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Controller registers; reset abandons any memory transaction at once.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      miss_tag_q <= '0;
      miss_idx_q <= '0;
      fill_q     <= '0;
    end else begin
      state_q    <= state_d;
      miss_tag_q <= miss_tag_d;
      miss_idx_q <= miss_idx_d;
      fill_q     <= fill_d;
    end
  end

  assign mem.MEM_READ      = mem_read;
  assign mem.MEM_WRITE     = mem_write;
  assign mem.MEM_ADDRESS   = mem_address;
  assign mem.MEM_WRITEDATA = mem_writedata;

endmodule

// File: tb/tb_dcache_controller.sv
// Scoreboard bench for dcache_controller: stimulus pushes expected CPU
// completions and memory transactions into queues, monitors pop and
// compare whenever the DUT completes one. Memory latency is 5 cycles.
module tb_dcache_controller;
  import dcache_controller_pkg::*;

  localparam int MEM_LAT = 5;

  typedef struct {
    string      name;
    bit         check_data;
    logic [7:0] data;
    int         stall;
  } cpu_exp_t;

  typedef struct {
    string       name;
    bit          is_write;
    logic [5:0]  addr;
    logic [31:0] wdata;
  } mem_exp_t;

  logic CLK;
  logic RESET;

  dcache_cpu_if cpu_bus ();
  dcache_mem_if mem_bus ();

  dcache_controller #(.INDEX_BITS(3)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .cpu   (cpu_bus.slave),
    .mem   (mem_bus.master)
  );

  cpu_exp_t cpu_q[$];
  mem_exp_t mem_q[$];
  int tests_run    = 0;
  int tests_failed = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- memory model ----------------
  logic [31:0] mem_array [64];
  int          mem_cnt;
  logic        mem_req;

  assign mem_req              = mem_bus.MEM_READ | mem_bus.MEM_WRITE;
  assign mem_bus.MEM_BUSYWAIT = mem_req && (mem_cnt < MEM_LAT - 1);
  assign mem_bus.MEM_READDATA = mem_array[mem_bus.MEM_ADDRESS];

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mem_cnt <= 0;
    end else if (mem_req) begin
      if (mem_bus.MEM_BUSYWAIT) begin
        mem_cnt <= mem_cnt + 1;
      end else begin
        mem_cnt <= 0;
        if (mem_bus.MEM_WRITE) mem_array[mem_bus.MEM_ADDRESS] <= mem_bus.MEM_WRITEDATA;
      end
    end else begin
      mem_cnt <= 0;
    end
  end

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- CPU-side monitor ----------------
  int stall_cnt = 0;
  always @(negedge CLK) begin
    cpu_exp_t e;
    if (RESET) begin
      stall_cnt = 0;
    end else if (cpu_bus.READ || cpu_bus.WRITE) begin
      if (cpu_bus.BUSYWAIT) begin
        stall_cnt++;
      end else begin
        if (cpu_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL unexpected_cpu_completion: addr 0x%0h, expected none", cpu_bus.ADDRESS);
        end else begin
          e = cpu_q.pop_front();
          $display("[TB] cpu %s addr=0x%02h rdata=0x%02h stall=%0d", e.name, cpu_bus.ADDRESS, cpu_bus.READDATA, stall_cnt);
          check({e.name, "_stall"}, stall_cnt, e.stall);
          if (e.check_data) check({e.name, "_rdata"}, {24'h0, cpu_bus.READDATA}, {24'h0, e.data});
        end
        stall_cnt = 0;
      end
    end
  end

  // ---------------- memory-side monitor ----------------
  always @(negedge CLK) begin
    mem_exp_t m;
    if (!RESET) begin
      if (mem_bus.MEM_READ && mem_bus.MEM_WRITE) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL mem_exclusive: MEM_READ and MEM_WRITE both 1, required at most one");
      end
      if (mem_req && !mem_bus.MEM_BUSYWAIT) begin
        if (mem_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL unexpected_mem_txn: wr=%0d addr 0x%0h, expected none",
                   mem_bus.MEM_WRITE, mem_bus.MEM_ADDRESS);
        end else begin
          m = mem_q.pop_front();
          $display("[TB] mem %s wr=%0d addr=0x%02h wdata=0x%08h", m.name, mem_bus.MEM_WRITE,
                   mem_bus.MEM_ADDRESS, mem_bus.MEM_WRITEDATA);
          check({m.name, "_kind"}, {31'h0, mem_bus.MEM_WRITE}, {31'h0, m.is_write});
          check({m.name, "_addr"}, {26'h0, mem_bus.MEM_ADDRESS}, {26'h0, m.addr});
          if (m.is_write) check({m.name, "_wdata"}, mem_bus.MEM_WRITEDATA, m.wdata);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic expect_mem(input string name, input bit wr, input logic [5:0] addr, input logic [31:0] wd);
    mem_exp_t m;
    m.name = name; m.is_write = wr; m.addr = addr; m.wdata = wd;
    mem_q.push_back(m);
  endtask

  task automatic cpu_op(input string name, input bit rd, input bit wr, input logic [7:0] addr,
                        input logic [7:0] wd, input logic [7:0] exp_rd, input int exp_stall);
    cpu_exp_t e;
    bit done;
    e.name = name; e.check_data = rd && !wr; e.data = exp_rd; e.stall = exp_stall;
    cpu_q.push_back(e);
    @(posedge CLK); #1;
    cpu_bus.READ      = rd;
    cpu_bus.WRITE     = wr;
    cpu_bus.ADDRESS   = addr;
    cpu_bus.WRITEDATA = wd;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge CLK);
      if (!cpu_bus.BUSYWAIT) done = 1'b1;
    end
    if (!done) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL %s_timeout: BUSYWAIT still 1 after 60 cycles, required 0", name);
    end
    @(posedge CLK); #1;
    cpu_bus.READ  = 1'b0;
    cpu_bus.WRITE = 1'b0;
  endtask

  initial begin
    bit seen;
    for (int i = 0; i < 64; i++) mem_array[i] = 32'h0;
    mem_array[6'h01] = 32'hDDCCBBAA;
    mem_array[6'h09] = 32'h44332211;
    mem_array[6'h20] = 32'h87654321;

    cpu_bus.READ = 1'b0; cpu_bus.WRITE = 1'b0;
    cpu_bus.ADDRESS = 8'h00; cpu_bus.WRITEDATA = 8'h00;
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    check("rst_busywait",  {31'h0, cpu_bus.BUSYWAIT},  32'h0);
    check("rst_mem_read",  {31'h0, mem_bus.MEM_READ},  32'h0);
    check("rst_mem_write", {31'h0, mem_bus.MEM_WRITE}, 32'h0);
    check("rst_mem_addr",  {26'h0, mem_bus.MEM_ADDRESS}, 32'h0);
    check("rst_mem_wdata", mem_bus.MEM_WRITEDATA, 32'h0);
    check("rst_readdata",  {24'h0, cpu_bus.READDATA}, 32'h0);
    RESET = 1'b0;

    // clean miss: 1 + 5 fetch + 1 update
    expect_mem("fill_01", 1'b0, 6'h01, 32'h0);
    cpu_op("rd04_miss", 1'b1, 1'b0, 8'h04, 8'h00, 8'hAA, 7);
    // same block, other offset hits
    cpu_op("rd06_hit", 1'b1, 1'b0, 8'h06, 8'h00, 8'hCC, 0);
    // store hit then load back
    cpu_op("wr05_hit", 1'b0, 1'b1, 8'h05, 8'h5A, 8'h00, 0);
    cpu_op("rd05_hit", 1'b1, 1'b0, 8'h05, 8'h00, 8'h5A, 0);
    // dirty miss to index 1: write back block 0x01, then fetch 0x09
    expect_mem("wb_01",   1'b1, 6'h01, 32'hDDCC5AAA);
    expect_mem("fill_09", 1'b0, 6'h09, 32'h0);
    cpu_op("rd24_dirty_miss", 1'b1, 1'b0, 8'h24, 8'h00, 8'h11, 12);

    // reset in the middle of the fetch of 0x80 (block 0x20)
    @(posedge CLK); #1;
    cpu_bus.READ = 1'b1; cpu_bus.ADDRESS = 8'h80;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge CLK);
      if (mem_bus.MEM_READ) seen = 1'b1;
    end
    check("fetch80_started", {31'h0, seen}, 32'h1);
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    check("midrst_mem_read", {31'h0, mem_bus.MEM_READ}, 32'h0);
    check("midrst_busywait", {31'h0, cpu_bus.BUSYWAIT}, 32'h0);
    check("midrst_mem_addr", {26'h0, mem_bus.MEM_ADDRESS}, 32'h0);
    cpu_bus.READ = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;

    // valid bits cleared: misses again; memory holds the written-back block
    expect_mem("refill_01", 1'b0, 6'h01, 32'h0);
    cpu_op("rd04_after_rst", 1'b1, 1'b0, 8'h04, 8'h00, 8'hAA, 7);
    // READ and WRITE together: the write wins
    cpu_op("rdwr04_hit", 1'b1, 1'b1, 8'h04, 8'h11, 8'h00, 0);
    cpu_op("rd04_after_wr", 1'b1, 1'b0, 8'h04, 8'h00, 8'h11, 0);

    repeat (5) @(posedge CLK);
    check("cpu_queue_drained", cpu_q.size(), 32'h0);
    check("mem_queue_drained", mem_q.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back data cache and its controller, placed between the 8-bit CPU's load/store path and the 32-bit-block data memory.
- Services byte reads and writes from the CPU.
- Stalls the CPU through BUSYWAIT on a miss, and sequences write-back and fetch with memory through a four-state FSM.

Parameters:
- INDEX_BITS, 3, number of index bits; the cache holds 2**INDEX_BITS blocks of 4 bytes each. TAG_BITS = 6 - INDEX_BITS.

Ports:
- CLK  in  1  system clock; all state updates occur on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- READ  in  1  CPU load request; held high until BUSYWAIT is low.
- WRITE  in  1  CPU store request; held high until BUSYWAIT is low.
- ADDRESS  in  8  byte address: [7:8-TAG_BITS] is the tag, then the index, then [1:0] is the byte offset.
- WRITEDATA  in  8  store data.
- READDATA  out  8  load data; valid whenever BUSYWAIT is low with READ high.
- BUSYWAIT  out  1  CPU stall.
- MEM_READ  out  1  block fetch request.
- MEM_WRITE  out  1  block write-back request.
- MEM_ADDRESS  out  6  block address, {tag,index}.
- MEM_WRITEDATA  out  32  victim block, byte0 = [7:0].
- MEM_READDATA  in  32  fetched block.
- MEM_BUSYWAIT  in  1  memory busy; memory raises it combinationally while a request is pending and drops it in the cycle its data or ack is valid.

Behaviour:
- Reset (asynchronous): all valid and dirty bits = 0; state = IDLE.
  - Outputs after reset: BUSYWAIT = 0, MEM_READ = 0, MEM_WRITE = 0, MEM_ADDRESS = 0, MEM_WRITEDATA = 0, READDATA = 0.
  - Data and tag arrays need not be cleared.
- Hit = valid[index] && tag[index] == ADDRESS tag.
- BUSYWAIT (combinational) = (READ|WRITE) && !(state == IDLE && hit).
- If READ and WRITE are both high, WRITE has priority.
- States:
  - IDLE: request with hit completes in the same cycle.
    - Read hit: READDATA = selected byte, combinational, zero added latency.
    - Write hit: at the rising edge, write the byte and set dirty[index] = 1.
    - Miss with dirty = 1 -> WRITEBACK.
    - Miss with dirty = 0 -> FETCH.
    - No request -> stay in IDLE.
  - WRITEBACK: MEM_WRITE = 1, MEM_ADDRESS = {stored tag, index}, MEM_WRITEDATA = stored block.
    - On an edge with MEM_BUSYWAIT = 0 -> FETCH.
  - FETCH: MEM_READ = 1, MEM_ADDRESS = {request tag, index}.
    - On an edge with MEM_BUSYWAIT = 0: capture MEM_READDATA into a block register -> UPDATE.
  - UPDATE: one cycle. Write the block, tag[index] = request tag, valid = 1, dirty = 0 -> IDLE.
    - The request then hits in the following cycle.
- MEM_READ and MEM_WRITE are never high simultaneously. Each is driven only in its own state.
- Latency:
  - Clean miss = F + 2 cycles, where F = FETCH cycles including the completing one.
  - Dirty miss = W + F + 2 cycles.
- If the request is dropped mid-miss, the FSM still completes the fill and returns to IDLE. No CPU write occurs.
- RESET asserted mid-miss: the memory transaction is abandoned immediately, MEM_* requests go low in the same cycle, and all valid bits are cleared.
- Tag-equal access to a different offset hits. Index wrap-around is not applicable because the index is a plain field.

Decomposition:
- Shared package: state encoding (IDLE, WRITEBACK, FETCH, UPDATE), address field widths, BLOCK_BYTES = 4.
- One sub-module, dcache_array: valid/dirty/tag/data storage.
  - Asynchronous read by index.
  - Synchronous byte-write and block-write ports.
  - Asynchronous clear on RESET.

Test Plan:
- Reset, then READ ADDRESS = 0x04 with memory latency 5 (block 0x01 = 0xDDCCBBAA).
  - BUSYWAIT high for 7 cycles.
  - MEM_READ high with MEM_ADDRESS = 0x01.
  - Then READDATA = 0xAA, and BUSYWAIT low in that same cycle.
- After the previous test: READ 0x06 -> hit, READDATA = 0xCC, BUSYWAIT never high, no MEM_* activity.
- WRITE 0x05 data 0x5A (hit), then READ 0x05 -> 0x5A. Dirty set; no memory write yet.
- READ 0x24 (same index 1, tag differs):
  - MEM_WRITE with MEM_ADDRESS = 0x01 and MEM_WRITEDATA = 0xDDCC5AAA.
  - Then MEM_READ with MEM_ADDRESS = 0x09.
  - Total stall = W + F + 2.
- Assert RESET during FETCH of 0x80:
  - MEM_READ and BUSYWAIT drop asynchronously.
  - A subsequent READ 0x04 misses (valid cleared).
- READ and WRITE both high at hit address 0x04 with WRITEDATA 0x11 -> byte written (WRITE priority). A subsequent READ returns 0x11.
